// File: rtl/multdiv_ctrl.sv
// Sequencing controller for an iterative multiply/divide datapath.
// Latches operands, drives init/step strobes and reports result-ready and exception.
module multdiv_ctrl #(
  parameter int MULT_STEPS = 16,
  parameter int DIV_STEPS  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        dp_overflow,
  input  logic        dp_special,
  output logic [31:0] opA_q,
  output logic [31:0] opB_q,
  output logic        dp_is_div,
  output logic        dp_init,
  output logic        dp_step,
  output logic        dp_zero,
  output logic        data_resultRDY,
  output logic        data_exception,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_STEPS - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_STEPS - 1);

  state_t      r_state;
  logic [5:0]  r_count;
  logic        r_divZero;
  logic        r_isDiv;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic        r_dpInit;
  logic        r_dpStep;
  logic        r_dpZero;
  logic        r_resultRdy;
  logic        r_exception;

  logic w_start;
  logic w_startDiv;
  logic w_startDivZero;

  // Multiply wins when both start lines are high.
  assign w_start        = ctrl_MULT | ctrl_DIV;
  assign w_startDiv     = ctrl_DIV & ~ctrl_MULT;
  assign w_startDivZero = w_startDiv & (data_operandB == 32'd0);

  // A start restarts from any state; strobes are registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= 6'd0;
      r_divZero   <= 1'b0;
      r_isDiv     <= 1'b0;
      r_opA       <= 32'd0;
      r_opB       <= 32'd0;
      r_dpInit    <= 1'b0;
      r_dpStep    <= 1'b0;
      r_dpZero    <= 1'b0;
      r_resultRdy <= 1'b0;
      r_exception <= 1'b0;
    end else begin
      r_dpInit    <= 1'b0;
      r_dpStep    <= 1'b0;
      r_dpZero    <= 1'b0;
      r_resultRdy <= 1'b0;
      r_exception <= 1'b0;
      if (w_start) begin
        r_opA     <= data_operandA;
        r_opB     <= data_operandB;
        r_isDiv   <= w_startDiv;
        r_divZero <= w_startDivZero;
        if (w_startDivZero) begin
          r_state     <= S_DONE;
          r_count     <= 6'd0;
          r_resultRdy <= 1'b1;
          r_exception <= 1'b1;
          r_dpZero    <= 1'b1;
        end else begin
          r_state  <= S_INIT;
          r_count  <= w_startDiv ? DIV_LOAD : MULT_LOAD;
          r_dpInit <= 1'b1;
        end
      end else begin
        case (r_state)
          S_INIT: begin
            r_state  <= S_RUN;
            r_dpStep <= 1'b1;
          end
          S_RUN: begin
            if (r_count == 6'd0) begin
              r_state     <= S_DONE;
              r_resultRdy <= 1'b1;
              r_exception <= r_isDiv ? r_divZero : (dp_overflow & ~dp_special);
            end else begin
              r_count  <= r_count - 6'd1;
              r_dpStep <= 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign opA_q          = r_opA;
  assign opB_q          = r_opB;
  assign dp_is_div      = r_isDiv;
  assign dp_init        = r_dpInit;
  assign dp_step        = r_dpStep;
  assign dp_zero        = r_dpZero;
  assign data_resultRDY = r_resultRdy;
  assign data_exception = r_exception;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes expected results,
// a monitor pops and compares them whenever data_resultRDY is seen.
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        dp_overflow;
  logic        dp_special;
  logic [31:0] opA_q;
  logic [31:0] opB_q;
  logic        dp_is_div;
  logic        dp_init;
  logic        dp_step;
  logic        dp_zero;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;

  typedef struct {
    int          cyc;
    bit          exc;
    bit          zero;
    bit          isDiv;
    logic [31:0] opA;
    logic [31:0] opB;
    int          inits;
    int          steps;
  } exp_t;

  exp_t expQ[$];
  int   cyc;
  int   checks;
  int   passes;
  int   initCount;
  int   stepCount;

  multdiv_ctrl #(.MULT_STEPS(16), .DIV_STEPS(32)) dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .dp_overflow(dp_overflow), .dp_special(dp_special),
    .opA_q(opA_q), .opB_q(opB_q), .dp_is_div(dp_is_div), .dp_init(dp_init),
    .dp_step(dp_step), .dp_zero(dp_zero), .data_resultRDY(data_resultRDY),
    .data_exception(data_exception), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Drives a one-cycle start and, if requested, queues its expected result.
  task automatic applyStimulus(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                               input bit doPush, input int lat, input bit exc, input bit zero,
                               input bit isDiv, input int inits, input int steps);
    exp_t e;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    if (doPush) begin
      e = '{cyc + lat, exc, zero, isDiv, a, b, inits, steps};
      expQ.push_back(e);
    end
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: counts strobes since the last result and scores each ready pulse.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      initCount = 0;
      stepCount = 0;
    end else begin
      if (dp_init) initCount++;
      if (dp_step) stepCount++;
      if (data_resultRDY) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("ready_cycle", cyc, e.cyc);
          checkOutput("exception", {31'd0, data_exception}, {31'd0, e.exc});
          checkOutput("dp_zero", {31'd0, dp_zero}, {31'd0, e.zero});
          checkOutput("dp_is_div", {31'd0, dp_is_div}, {31'd0, e.isDiv});
          checkOutput("opA_q", opA_q, e.opA);
          checkOutput("opB_q", opB_q, e.opB);
          checkOutput("init_pulses", initCount, e.inits);
          checkOutput("step_pulses", stepCount, e.steps);
          checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
        end
        initCount = 0;
        stepCount = 0;
      end
    end
  end

  initial begin
    int k;
    initCount     = 0;
    stepCount     = 0;
    checks        = 0;
    passes        = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    dp_overflow   = 1'b0;
    dp_special    = 1'b0;
    waitCycles(3);
    checkOutput("reset_opA", opA_q, 32'd0);
    checkOutput("reset_opB", opB_q, 32'd0);
    checkOutput("reset_ctrl", {25'd0, dp_is_div, dp_init, dp_step, dp_zero, data_resultRDY, data_exception, busy}, 32'd0);
    reset = 1'b0;

    // Plain multiply issued on the first edge after reset.
    applyStimulus(1, 0, 32'd7, 32'd6, 1, 18, 0, 0, 0, 1, 16);
    checkOutput("init_strobe", {31'd0, dp_init}, 32'd1);
    checkOutput("busy_init", {31'd0, busy}, 32'd1);
    waitCycles(20);

    // Divide by zero finishes immediately.
    applyStimulus(0, 1, 32'd100, 32'd0, 1, 1, 1, 1, 1, 0, 0);
    waitCycles(3);

    // Overflow masked by the special -2^31 product, then reported without it.
    dp_overflow = 1'b1;
    dp_special  = 1'b1;
    applyStimulus(1, 0, 32'hFFFF8000, 32'h00010000, 1, 18, 0, 0, 0, 1, 16);
    waitCycles(20);
    dp_special = 1'b0;
    applyStimulus(1, 0, 32'hFFFF8000, 32'h00010000, 1, 18, 1, 0, 0, 1, 16);
    waitCycles(20);
    dp_overflow = 1'b0;

    // Multiply aborted by a divide presented six cycles later.
    applyStimulus(1, 0, 32'd3, 32'd5, 0, 0, 0, 0, 0, 0, 0);
    waitCycles(5);
    applyStimulus(0, 1, 32'd100, 32'd7, 1, 34, 0, 0, 1, 2, 37);
    checkOutput("abort_is_div", {31'd0, dp_is_div}, 32'd1);
    checkOutput("abort_opB", opB_q, 32'd7);
    waitCycles(36);

    // Reset in the middle of a divide clears everything at once.
    applyStimulus(0, 1, 32'd50, 32'd3, 0, 0, 0, 0, 0, 0, 0);
    waitCycles(9);
    reset = 1'b1;
    #1;
    checkOutput("midrst_opA", opA_q, 32'd0);
    checkOutput("midrst_opB", opB_q, 32'd0);
    checkOutput("midrst_ctrl", {25'd0, dp_is_div, dp_init, dp_step, dp_zero, data_resultRDY, data_exception, busy}, 32'd0);
    waitCycles(2);
    reset = 1'b0;
    waitCycles(40);

    // Both starts high with B=0: multiply wins, no divide-by-zero.
    applyStimulus(1, 1, 32'd9, 32'd0, 1, 18, 0, 0, 0, 1, 16);
    waitCycles(20);

    // New start coincident with DONE still yields the current ready pulse.
    applyStimulus(1, 0, 32'd2, 32'd3, 1, 18, 0, 0, 0, 1, 16);
    waitCycles(17);
    applyStimulus(1, 0, 32'd4, 32'd5, 1, 18, 0, 0, 0, 1, 16);
    waitCycles(20);

    // Start held for five edges restarts each time.
    k = cyc;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd11;
    data_operandB = 32'd13;
    expQ.push_back('{k + 4 + 18, 1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 5, 16});
    waitCycles(5);
    ctrl_MULT = 1'b0;

    for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clock);
    waitCycles(5);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter MULT_STEPS, default 16, SHALL set the number of datapath iterations for a multiply (radix-4 Booth).
REQ-002 Parameter DIV_STEPS, default 32, SHALL set the number of datapath iterations for a divide; legal range for both parameters is 1..63.
REQ-003 Clocking and reset SHALL be exactly as decided: one clock; reset is asynchronous and active-high.
REQ-004 Port list SHALL be, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  async active-high reset.
- ctrl_MULT  in  1  start multiply, sampled each edge.
- ctrl_DIV  in  1  start divide, sampled each edge.
- data_operandA  in  32  operand A.
- data_operandB  in  32  operand B.
- dp_overflow  in  1  datapath raw multiply-overflow flag.
- dp_special  in  1  datapath flag: operands form a representable -2^31 product; overrides overflow.
- opA_q  out  32  latched operand A to datapath.
- opB_q  out  32  latched operand B to datapath.
- dp_is_div  out  1  operation select (1 = divide).
- dp_init  out  1  datapath load strobe.
- dp_step  out  1  datapath iteration enable.
- dp_zero  out  1  force result to zero (divide by zero).
- data_resultRDY  out  1  result-valid pulse.
- data_exception  out  1  exception, valid with data_resultRDY.
- busy  out  1  operation in flight.

Function
REQ-005 The FSM SHALL have states IDLE, INIT, RUN and DONE, encoded in 2 bits.
REQ-006 A start is ctrl_MULT or ctrl_DIV high at a rising edge; when both are high, the start SHALL be a multiply.
REQ-007 A start SHALL be accepted in any state, abort any operation in flight, latch the operands into opA_q/opB_q, and latch dp_is_div at that edge.
REQ-008 Divide-by-zero (data_operandB == 0 with a divide start) SHALL set a divzero flag and move the FSM to DONE on the next cycle, skipping INIT and RUN.
REQ-009 For any other start, the FSM SHALL move to INIT, where dp_init = 1 for exactly one cycle and a 6-bit step counter loads STEPS-1.
REQ-010 The FSM SHALL move from INIT to RUN; in RUN, dp_step = 1 every cycle and the counter decrements.
REQ-011 The FSM SHALL move from RUN to DONE on the cycle the counter equals 0; the counter SHALL never wrap.
REQ-012 In DONE, data_resultRDY SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE unless a start is present.
REQ-013 Latency SHALL be as follows, for a start at edge k:
- INIT occupies cycle k+1.
- RUN occupies cycles k+2 .. k+STEPS+1.
- DONE occupies cycle k+STEPS+2.
- A divide-by-zero reaches DONE at cycle k+1.
REQ-014 data_exception SHALL equal the following in DONE, and 0 in all other states:
- divide: divzero.
- multiply: dp_overflow AND NOT dp_special.
REQ-015 dp_zero SHALL be 1 only in the DONE cycle of a divide-by-zero.
REQ-016 busy SHALL be 1 in INIT, RUN and DONE.
REQ-017 opA_q and opB_q SHALL hold their values until the next start.
REQ-018 A start coincident with DONE SHALL still produce the current data_resultRDY pulse; the new operation then begins at INIT on the next cycle.
REQ-019 ctrl_* inputs held high for several cycles SHALL restart the operation on each edge, so data_resultRDY never fires while a start is held.

Reset
REQ-020 While reset is high, and asynchronously upon its assertion, the block SHALL hold:
- state IDLE.
- counter, divzero, opA_q, opB_q and dp_is_div at 0.
- all outputs at 0.
REQ-021 Reset asserted mid-RUN SHALL abort the operation with no data_resultRDY pulse.
REQ-022 The first start SHALL be honoured on the first rising edge after reset deasserts.

Verification
REQ-023 MULT start, A=7, B=6, dp_overflow=0 -> dp_init at cycle 1, dp_step for cycles 2..17, data_resultRDY at cycle 18 only, data_exception=0.
REQ-024 DIV start, A=100, B=0 -> data_resultRDY, data_exception and dp_zero all 1 at cycle 1; dp_init and dp_step never asserted.
REQ-025 MULT start, A=0xFFFF8000, B=0x00010000, dp_overflow=1, dp_special=1 -> data_exception=0 at cycle 18; the same operation with dp_special=0 -> data_exception=1.
REQ-026 MULT start, then DIV start (A=100, B=7) at cycle 6 -> no ready at cycle 18, dp_is_div=1 and opB_q=7 from cycle 7, data_resultRDY at cycle 40.
REQ-027 Reset pulse at cycle 10 of a DIV -> all outputs 0 immediately and no data_resultRDY thereafter.
REQ-028 ctrl_MULT and ctrl_DIV both high at one edge with B=0 -> multiply performed, dp_is_div=0, data_resultRDY at cycle 18, dp_zero=0.
